// File: rtl/vertex_transform_pipe.sv
// vertex_transform_pipe: 4x4 fixed-point vertex transform with view-volume clip and a
// sequential perspective divide to screen coordinates; valid/ready handshake on both sides.
module vertex_transform_pipe #(
    parameter int W     = 10,
    parameter int CW    = 16,
    parameter int FRAC  = 8,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480,
    parameter int SXW   = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mat_we,
    input  logic [3:0]     mat_addr,
    input  logic [CW-1:0]  mat_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    input  logic [W-1:0]   in_z,
    input  logic [W-1:0]   in_w,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   out_cx,
    output logic [W+1:0]   out_cy,
    output logic [W+1:0]   out_cz,
    output logic [W+1:0]   out_cw,
    output logic [SXW-1:0] out_sx,
    output logic [SXW-1:0] out_sy,
    output logic           out_clip
);

    localparam int AW   = W + CW + 2;
    localparam int CXW  = W + 2;
    localparam int DW   = W + SXW + 4;
    localparam int CNTW = $clog2(SXW) + 1;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (W + 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (W + 1)));
    localparam logic [SXW-1:0]       SX_MAX  = SXW'(SCR_W - 1);
    localparam logic [SXW-1:0]       SY_MAX  = SXW'(SCR_H - 1);
    localparam logic [CNTW-1:0]      ROW_LAST = CNTW'(3);
    localparam logic [CNTW-1:0]      DIV_LAST = CNTW'(SXW - 1);

    localparam logic [CW-1:0] C_ONE = CW'(1 << FRAC);
    localparam logic [CW-1:0] C_ZRO = '0;
    localparam logic [15:0][CW-1:0] IDENT = {C_ONE, C_ZRO, C_ZRO, C_ZRO,
                                             C_ZRO, C_ONE, C_ZRO, C_ZRO,
                                             C_ZRO, C_ZRO, C_ONE, C_ZRO,
                                             C_ZRO, C_ZRO, C_ZRO, C_ONE};

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        SAT,
        DIVX,
        DIVY,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [15:0][CW-1:0]  mat;
    logic signed [W-1:0]  vx;
    logic signed [W-1:0]  vy;
    logic signed [W-1:0]  vz;
    logic signed [W-1:0]  vw;
    logic [3:0][AW-1:0]   rows;
    logic signed [CXW-1:0] cx;
    logic signed [CXW-1:0] cy;
    logic signed [CXW-1:0] cz;
    logic signed [CXW-1:0] cw;
    logic                  clip;
    logic [CNTW-1:0]       cnt;
    logic [DW-1:0]         rem;
    logic [DW-1:0]         den_sh;
    logic [SXW-2:0]        quo;
    logic [SXW-1:0]        qx;

    logic signed [AW-1:0]  row_sum;
    logic signed [CXW-1:0] cx_s;
    logic signed [CXW-1:0] cy_s;
    logic signed [CXW-1:0] cz_s;
    logic signed [CXW-1:0] cw_s;
    logic signed [CXW:0]   ax_s;
    logic signed [CXW:0]   ay_s;
    logic signed [CXW:0]   cw_e;
    logic signed [CXW:0]   sum_x;
    logic signed [CXW:0]   dif_y;
    logic                  clip_s;
    logic [DW-1:0]         num_x;
    logic [DW-1:0]         num_y;
    logic [DW-1:0]         den_x;
    logic [DW-1:0]         den_y;
    logic                  div_ge;
    logic [DW-1:0]         rem_step;
    logic [SXW-1:0]        quo_nx;
    logic                  div_last;

    function automatic logic signed [CXW-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[CXW-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[CXW-1:0];
        else
            return v[CXW-1:0];
    endfunction

    function automatic logic [SXW-1:0] clampq(input logic [SXW-1:0] q, input logic [SXW-1:0] lim);
        return (q > lim) ? lim : q;
    endfunction

    // One matrix row per MUL cycle, selected by the low bits of cnt.
    always_comb begin
        row_sum = AW'($signed(mat[{cnt[1:0], 2'd0}])) * AW'(vx)
                + AW'($signed(mat[{cnt[1:0], 2'd1}])) * AW'(vy)
                + AW'($signed(mat[{cnt[1:0], 2'd2}])) * AW'(vz)
                + AW'($signed(mat[{cnt[1:0], 2'd3}])) * AW'(vw);
    end

    always_comb begin
        cx_s   = sat($signed(rows[0]));
        cy_s   = sat($signed(rows[1]));
        cz_s   = sat($signed(rows[2]));
        cw_s   = sat($signed(rows[3]));
        cw_e   = (CXW + 1)'(cw_s);
        ax_s   = cx_s[CXW-1] ? -((CXW + 1)'(cx_s)) : (CXW + 1)'(cx_s);
        ay_s   = cy_s[CXW-1] ? -((CXW + 1)'(cy_s)) : (CXW + 1)'(cy_s);
        clip_s = cw_s[CXW-1] || (cw_s == '0) || (ax_s > cw_e) || (ay_s > cw_e);
        sum_x  = (CXW + 1)'(cx_s) + cw_e;
        num_x  = DW'(sum_x) * DW'(SCR_W / 2);
        den_x  = DW'($unsigned(cw_s)) << (SXW - 1);
        // y numerator and denominator come from the registered clip coordinates
        dif_y  = (CXW + 1)'(cw) - (CXW + 1)'(cy);
        num_y  = DW'(dif_y) * DW'(SCR_H / 2);
        den_y  = DW'($unsigned(cw)) << (SXW - 1);
    end

    always_comb begin
        div_ge   = rem >= den_sh;
        rem_step = div_ge ? rem - den_sh : rem;
        quo_nx   = {quo, div_ge};
        div_last = cnt == DIV_LAST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = MUL;
            end
            MUL:     if (cnt == ROW_LAST) state_nx = SAT;
            SAT:     state_nx = DIVX;
            DIVX:    if (div_last) state_nx = DIVY;
            DIVY:    if (div_last) state_nx = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat      <= IDENT;
            vx       <= '0;
            vy       <= '0;
            vz       <= '0;
            vw       <= '0;
            rows     <= '0;
            cx       <= '0;
            cy       <= '0;
            cz       <= '0;
            cw       <= '0;
            clip     <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            den_sh   <= '0;
            quo      <= '0;
            qx       <= '0;
            out_cx   <= '0;
            out_cy   <= '0;
            out_cz   <= '0;
            out_cw   <= '0;
            out_sx   <= '0;
            out_sy   <= '0;
            out_clip <= 1'b0;
        end else begin
            if (state == IDLE && mat_we)
                mat[mat_addr] <= mat_data;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vx  <= $signed(in_x);
                        vy  <= $signed(in_y);
                        vz  <= $signed(in_z);
                        vw  <= $signed(in_w);
                        cnt <= '0;
                    end
                end
                MUL: begin
                    rows[cnt[1:0]] <= row_sum >>> FRAC;
                    cnt            <= (cnt == ROW_LAST) ? '0 : cnt + 1'b1;
                end
                SAT: begin
                    cx     <= cx_s;
                    cy     <= cy_s;
                    cz     <= cz_s;
                    cw     <= cw_s;
                    clip   <= clip_s;
                    rem    <= num_x;
                    den_sh <= den_x;
                    quo    <= '0;
                    cnt    <= '0;
                end
                DIVX: begin
                    if (div_last) begin
                        qx     <= clampq(quo_nx, SX_MAX);
                        rem    <= num_y;
                        den_sh <= den_y;
                        quo    <= '0;
                        cnt    <= '0;
                    end else begin
                        rem    <= rem_step;
                        den_sh <= den_sh >> 1;
                        quo    <= quo_nx[SXW-2:0];
                        cnt    <= cnt + 1'b1;
                    end
                end
                DIVY: begin
                    if (div_last) begin
                        // Divides always run to keep latency fixed; clipped vertices report 0,0.
                        out_cx   <= cx;
                        out_cy   <= cy;
                        out_cz   <= cz;
                        out_cw   <= cw;
                        out_clip <= clip;
                        out_sx   <= clip ? '0 : qx;
                        out_sy   <= clip ? '0 : clampq(quo_nx, SY_MAX);
                        cnt      <= '0;
                    end else begin
                        rem    <= rem_step;
                        den_sh <= den_sh >> 1;
                        quo    <= quo_nx[SXW-2:0];
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_transform_pipe.sv
// Self-checking bench for vertex_transform_pipe: directed cases plus randomized vertices
// checked against an arithmetic reference model of transform, clip and screen mapping.
module tb_vertex_transform_pipe;

    localparam int W     = 10;
    localparam int CW    = 16;
    localparam int FRAC  = 8;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int SXW   = 11;
    localparam int PW    = 4 * (W + 2) + 2 * SXW + 1;
    localparam int LAT   = 5 + 2 * SXW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mat_we = 1'b0;
    logic [3:0]     mat_addr = '0;
    logic [CW-1:0]  mat_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_x = '0;
    logic [W-1:0]   in_y = '0;
    logic [W-1:0]   in_z = '0;
    logic [W-1:0]   in_w = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W+1:0]   out_cx;
    logic [W+1:0]   out_cy;
    logic [W+1:0]   out_cz;
    logic [W+1:0]   out_cw;
    logic [SXW-1:0] out_sx;
    logic [SXW-1:0] out_sy;
    logic           out_clip;
    logic [PW-1:0]  got_all;

    int n_checks = 0;
    int n_fail   = 0;
    int mm[16];

    always #5 clk = ~clk;

    vertex_transform_pipe #(
        .W(W), .CW(CW), .FRAC(FRAC), .SCR_W(SCR_W), .SCR_H(SCR_H), .SXW(SXW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mat_we(mat_we), .mat_addr(mat_addr), .mat_data(mat_data),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cx(out_cx), .out_cy(out_cy), .out_cz(out_cz), .out_cw(out_cw),
        .out_sx(out_sx), .out_sy(out_sy), .out_clip(out_clip)
    );

    assign got_all = {out_cx, out_cy, out_cz, out_cw, out_sx, out_sy, out_clip};

    // Reference: exact matrix product, floor shift, saturate, clip test, clamped screen map.
    function automatic logic [PW-1:0] model(input int x, input int y, input int z, input int w);
        int     v[4];
        int     r[4];
        longint acc;
        bit     clip;
        int     sx;
        int     sy;
        int     lim;
        lim  = (1 << (W + 1));
        v[0] = x; v[1] = y; v[2] = z; v[3] = w;
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            for (int j = 0; j < 4; j++)
                acc += longint'(mm[i * 4 + j]) * longint'(v[j]);
            acc = acc >>> FRAC;
            if (acc > lim - 1) acc = lim - 1;
            else if (acc < -lim) acc = -lim;
            r[i] = int'(acc);
        end
        clip = (r[3] <= 0) || ((r[0] < 0 ? -r[0] : r[0]) > r[3]) || ((r[1] < 0 ? -r[1] : r[1]) > r[3]);
        sx = 0;
        sy = 0;
        if (!clip) begin
            sx = (r[0] + r[3]) * (SCR_W / 2) / r[3];
            sy = (r[3] - r[1]) * (SCR_H / 2) / r[3];
            if (sx > SCR_W - 1) sx = SCR_W - 1;
            if (sy > SCR_H - 1) sy = SCR_H - 1;
        end
        return {(W + 2)'(r[0]), (W + 2)'(r[1]), (W + 2)'(r[2]), (W + 2)'(r[3]),
                SXW'(sx), SXW'(sy), clip};
    endfunction

    task automatic tb_identity();
        for (int k = 0; k < 16; k++) mm[k] = (k % 5 == 0) ? (1 << FRAC) : 0;
    endtask

    task automatic write_coeff(input int addr, input int data);
        mat_we = 1'b1; mat_addr = 4'(addr); mat_data = CW'(data);
        @(posedge clk); #1;
        mat_we = 1'b0;
        mm[addr] = data;
    endtask

    task automatic set_identity();
        for (int k = 0; k < 16; k++) write_coeff(k, (k % 5 == 0) ? (1 << FRAC) : 0);
    endtask

    // Presents one vertex (optionally with a coefficient write on the accept edge) and
    // returns the cycle count from accept to out_valid, capped at 200.
    task automatic send_vertex(input int x, input int y, input int z, input int w,
                               input bit wr, input int waddr, input int wdata, output int lat);
        in_x = W'(x); in_y = W'(y); in_z = W'(z); in_w = W'(w);
        in_valid = 1'b1;
        if (wr) begin
            mat_we = 1'b1; mat_addr = 4'(waddr); mat_data = CW'(wdata);
            mm[waddr] = wdata;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        mat_we   = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (got_all !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", got_all); end
        rst_n = 1'b1;
        tb_identity();
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        int lat;
        int vx[3] = '{1, 0, -20};
        int vy[3] = '{1, 0, 35};
        int vz[3] = '{0, 0, 7};
        int vw[3] = '{1, 1, 100};
        logic [PW-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            send_vertex(vx[i], vy[i], vz[i], vw[i], 1'b0, 0, 0, lat);
            exp = model(vx[i], vy[i], vz[i], vw[i]);
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL identity[%0d] latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL identity[%0d] result: got %h expected %h", i, got_all, exp); end
            if (i == 0) begin
                n_checks++;
                if (out_sx !== 11'd639 || out_sy !== 11'd0 || out_clip !== 1'b0) begin
                    n_fail++; $display("FAIL identity_corner: got sx=%0d sy=%0d clip=%b expected 639 0 0", out_sx, out_sy, out_clip);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (out_sx !== 11'd320 || out_sy !== 11'd240 || out_clip !== 1'b0) begin
                    n_fail++; $display("FAIL identity_centre: got sx=%0d sy=%0d clip=%b expected 320 240 0", out_sx, out_sy, out_clip);
                end
            end
            take_output();
        end
    endtask

    task automatic test_scale();
        int lat;
        logic [PW-1:0] exp;
        for (int k = 0; k < 16; k += 5) write_coeff(k, 512);
        send_vertex(100, 50, 0, 200, 1'b0, 0, 0, lat);
        exp = model(100, 50, 0, 200);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL scale latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL scale result: got %h expected %h", got_all, exp); end
        n_checks++;
        if (out_cx !== 12'd200 || out_cy !== 12'd100 || out_cw !== 12'd400 || out_sx !== 11'd480 || out_sy !== 11'd180) begin
            n_fail++;
            $display("FAIL scale_values: got cx=%0d cy=%0d cw=%0d sx=%0d sy=%0d expected 200 100 400 480 180",
                     out_cx, out_cy, out_cw, out_sx, out_sy);
        end
        take_output();
    endtask

    task automatic test_clip();
        int lat;
        int vx[3] = '{5, 0, 0};
        int vw[3] = '{1, 0, -3};
        logic [PW-1:0] exp;
        for (int k = 0; k < 16; k += 5) write_coeff(k, 1 << FRAC);
        for (int i = 0; i < 3; i++) begin
            send_vertex(vx[i], 0, 0, vw[i], 1'b0, 0, 0, lat);
            exp = model(vx[i], 0, 0, vw[i]);
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL clip[%0d] latency: got %0d expected %0d", i, lat, LAT); end
            n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL clip[%0d] result: got %h expected %h", i, got_all, exp); end
            n_checks++;
            if (out_clip !== 1'b1 || out_sx !== '0 || out_sy !== '0) begin
                n_fail++; $display("FAIL clip[%0d] flag: got clip=%b sx=%0d sy=%0d expected 1 0 0", i, out_clip, out_sx, out_sy);
            end
            take_output();
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [PW-1:0] exp;
        for (int k = 0; k < 16; k++) write_coeff(k, 32767);
        send_vertex(511, 511, 511, 511, 1'b0, 0, 0, lat);
        exp = model(511, 511, 511, 511);
        n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL saturation result: got %h expected %h", got_all, exp); end
        n_checks++;
        if ({out_cx, out_cy, out_cz, out_cw} !== {4{12'd2047}}) begin
            n_fail++; $display("FAIL saturation_coords: got %0d %0d %0d %0d expected 2047 each", out_cx, out_cy, out_cz, out_cw);
        end
        take_output();
    endtask

    task automatic test_write_gating();
        int lat;
        logic [PW-1:0] exp;
        set_identity();
        in_x = W'(10); in_y = W'(20); in_z = W'(0); in_w = W'(40);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mat_we = 1'b1; mat_addr = 4'd0; mat_data = '0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        mat_we = 1'b0;
        exp = model(10, 20, 0, 40);
        n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL gating_first result: got %h expected %h", got_all, exp); end
        take_output();
        send_vertex(3, 4, 0, 10, 1'b0, 0, 0, lat);
        exp = model(3, 4, 0, 10);
        n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL gating_follow result: got %h expected %h", got_all, exp); end
        take_output();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [PW-1:0] exp;
        send_vertex(-50, 30, 0, 120, 1'b0, 0, 0, lat);
        exp = model(-50, 30, 0, 120);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL backpressure latency: got %0d expected %0d", lat, LAT); end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (got_all !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got %h ready=%b valid=%b expected %h ready=0 valid=1",
                         c, got_all, in_ready, out_valid, exp);
            end
            @(posedge clk); #1;
        end
        take_output();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid); end
    endtask

    task automatic test_reset_midflight();
        int lat;
        logic [PW-1:0] exp;
        for (int k = 0; k < 16; k += 5) write_coeff(k, 512);
        in_x = W'(40); in_y = W'(-20); in_z = W'(0); in_w = W'(90);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (got_all !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", got_all); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tb_identity();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got out_valid=%b expected 0", out_valid); end
        send_vertex(7, -3, 0, 20, 1'b0, 0, 0, lat);
        exp = model(7, -3, 0, 20);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL midreset_next latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL midreset_next result: got %h expected %h", got_all, exp); end
        take_output();
    endtask

    task automatic test_random();
        int lat, x, y, z, w, a, d;
        bit wr;
        logic [PW-1:0] exp;
        for (int it = 0; it < 36; it++) begin
            if (it % 6 == 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (it % 12 == 6)    d = int'($urandom_range(0, 65535)) - 32768;
                    else if (k % 5 == 0) d = int'($urandom_range(160, 400));
                    else                 d = int'($urandom_range(0, 127)) - 64;
                    write_coeff(k, d);
                end
            end
            x  = int'($urandom_range(0, 1023)) - 512;
            y  = int'($urandom_range(0, 1023)) - 512;
            z  = int'($urandom_range(0, 1023)) - 512;
            w  = int'($urandom_range(0, 711)) - 200;
            wr = ($urandom_range(0, 2) == 0);
            a  = int'($urandom_range(0, 15));
            d  = (a % 5 == 0) ? int'($urandom_range(160, 400)) : int'($urandom_range(0, 127)) - 64;
            send_vertex(x, y, z, w, wr, a, d, lat);
            exp = model(x, y, z, w);
            n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL random[%0d] latency: got %0d expected %0d", it, lat, LAT); end
            n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL random[%0d] result (%0d,%0d,%0d,%0d): got %h expected %h", it, x, y, z, w, got_all, exp); end
            take_output();
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 5;
        int bx[N], by[N], bz[N], bw[N];
        int idx, got_n, cyc;
        bit acc;
        logic [PW-1:0] q[$];
        logic [PW-1:0] exp;
        set_identity();
        for (int i = 0; i < N; i++) begin
            bx[i] = int'($urandom_range(0, 399)) - 200;
            by[i] = int'($urandom_range(0, 399)) - 200;
            bz[i] = int'($urandom_range(0, 1023)) - 512;
            bw[i] = int'($urandom_range(1, 511));
        end
        idx = 0; got_n = 0; cyc = 0;
        out_ready = 1'b1;
        in_x = W'(bx[0]); in_y = W'(by[0]); in_z = W'(bz[0]); in_w = W'(bw[0]);
        in_valid = 1'b1;
        while (got_n < N && cyc < 400) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back(model(bx[idx], by[idx], bz[idx], bw[idx]));
                idx++;
                if (idx < N) begin
                    in_x = W'(bx[idx]); in_y = W'(by[idx]); in_z = W'(bz[idx]); in_w = W'(bw[idx]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : '1;
                n_checks++; if (got_all !== exp) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", got_n, got_all, exp); end
                got_n++;
            end
        end
        n_checks++; if (got_n !== N) begin n_fail++; $display("FAIL back_to_back_count: got %0d expected %0d", got_n, N); end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_scale();
        test_clip();
        test_saturation();
        test_write_gating();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
